// File: rtl/fetch_stage.sv
// Instruction-fetch front end: issues imem requests for pcF, fills the decode register,
// absorbs decode stalls with a one-entry skid buffer and squashes on decode flushes.
module fetch_stage #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP  = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] pcF,
    input  logic             stallD,
    input  logic             flushD,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pcplus4F,
    output logic             stallF,
    output logic [WIDTH-1:0] instrD,
    output logic [WIDTH-1:0] pcplus4D,
    output logic             validD
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] bufInstr_q, bufInstr_d;
    logic [WIDTH-1:0] bufPc4_q, bufPc4_d;
    logic [WIDTH-1:0] reqAddr_q, reqAddr_d;

    assign pcplus4F = pcF + WIDTH'(4);
    assign instrD   = instr_q;
    assign pcplus4D = pc4_q;
    assign validD   = valid_q;

    // DROP keeps presenting the abandoned address so the memory contract holds across a flush
    assign imem_req  = clr_n && (state_q == RUN || state_q == DROP);
    assign imem_addr = (state_q == DROP) ? reqAddr_q : pcF;

    always_comb begin
        stallF = 1'b1;
        if (clr_n) begin
            if (flushD)
                stallF = 1'b0;
            else if (state_q == RUN && imem_ack)
                stallF = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        bufInstr_d = bufInstr_q;
        bufPc4_d   = bufPc4_q;
        reqAddr_d  = reqAddr_q;

        unique case (state_q)
            RUN: begin
                if (flushD) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    if (!imem_ack) begin
                        reqAddr_d = pcF;
                        state_d   = DROP;
                    end
                end else if (imem_ack) begin
                    if (stallD) begin
                        bufInstr_d = imem_rdata;
                        bufPc4_d   = pcplus4F;
                        state_d    = HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pcplus4F;
                        valid_d = 1'b1;
                    end
                end else if (!stallD) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (flushD) begin
                    instr_d    = NOP;
                    pc4_d      = '0;
                    valid_d    = 1'b0;
                    bufInstr_d = '0;
                    bufPc4_d   = '0;
                    state_d    = RUN;
                end else if (!stallD) begin
                    instr_d = bufInstr_q;
                    pc4_d   = bufPc4_q;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
            end
            DROP: begin
                if (flushD || !stallD) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
                if (imem_ack)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= RUN;
            instr_q    <= NOP;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            bufInstr_q <= '0;
            bufPc4_q   <= '0;
            reqAddr_q  <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            bufInstr_q <= bufInstr_d;
            bufPc4_q   <= bufPc4_d;
            reqAddr_q  <= reqAddr_d;
        end
    end

endmodule
